fetch_sequencer: RTL and testbench

- Fetch-stage controller that sequences the PC register (address generator) against a handshaked instruction memory.
- Drives the PC register's stall, select and target inputs; issues imem requests; and buffers branch redirects that arrive while a fetch is outstanding.
- Presents one-entry-buffered instructions to the IF/ID boundary and pulses a decode flush on redirect.
- Sits between the EX-stage branch unit, the hazard unit, the PC register and instruction memory.

---
 rtl/fetch_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Fetch-stage controller. Sequences the PC register against a handshaked
// instruction memory, buffers EX-stage redirects that arrive while a fetch
// is outstanding, and presents a one-entry instruction buffer to IF/ID.
//
// Optional feature (macro FETCH_TIMEOUT_EN): a WAIT-state watchdog that, after
// TIMEOUT_CYC cycles without a response, raises the sticky fetch_err flag,
// discards the lost response and re-fetches the same address. Without the
// macro the watchdog is absent, fetch_err is 0 and WAIT waits indefinitely.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   pc                    current PC from the PC register
//   hazard_stall          decode stalled by the hazard unit
//   br_sel, pc_bru        EX-stage redirect pulse and its target
//   ag_stall_f            PC register hold
//   ag_br_sel, ag_pc_bru  PC register select-target and target
//   imem_req, imem_addr   fetch request and address
//   imem_gnt              request accepted this cycle
//   imem_rvalid, imem_rdata  response valid and data
//   if_valid, if_instr, if_pc  IF/ID instruction buffer
//   flush_d               one-cycle decode flush (same cycle as br_sel)
//   fetch_err             sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013,
    parameter int              TIMEOUT_CYC = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] pc,
    input  logic            hazard_stall,
    input  logic            br_sel,
    input  logic [XLEN-1:0] pc_bru,
    output logic            ag_stall_f,
    output logic            ag_br_sel,
    output logic [XLEN-1:0] ag_pc_bru,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            flush_d,
    output logic            fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            pend_valid_r;
    logic [XLEN-1:0] pend_tgt_r;
    logic            kill_r;
    logic [XLEN-1:0] req_pc_r;
    logic            buf_valid_r;
    logic [XLEN-1:0] buf_instr_r;
    logic [XLEN-1:0] buf_pc_r;
    logic            issue_s;
    logic            grant_s;
    logic            load_s;
    logic            timeout_hit_s;
    logic            stall_s;
    logic            br_out_s;

    // Next-state and handshake decode.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b1;
        br_out_s    = 1'b0;
        issue_s     = 1'b0;
        grant_s     = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                state_nxt_s = REQ;
            end
            REQ: begin
                // A redirect seen this cycle is latched at the edge, so REDIR
                // can apply it immediately without a wasted REQ cycle.
                if (pend_valid_r || br_sel) begin
                    state_nxt_s = REDIR;
                end else if (buf_valid_r && hazard_stall) begin
                    state_nxt_s = REQ;
                end else begin
                    issue_s = 1'b1;
                    if (imem_gnt) begin
                        grant_s     = 1'b1;
                        stall_s     = 1'b0;
                        state_nxt_s = WAIT;
                    end else begin
                        state_nxt_s = REQ;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    // Responses to a squashed fetch (kill or a same-cycle
                    // redirect) are dropped.
                    load_s      = !kill_r && !br_sel;
                    state_nxt_s = REQ;
                end else if (timeout_hit_s) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            REDIR: begin
                br_out_s    = 1'b1;
                stall_s     = 1'b0;
                state_nxt_s = REQ;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pending redirect: a newer br_sel always wins over a watchdog re-fetch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_valid_r <= 1'b0;
            pend_tgt_r   <= {XLEN{1'b0}};
        end else if (br_sel) begin
            pend_valid_r <= 1'b1;
            pend_tgt_r   <= pc_bru;
        end else if (timeout_hit_s) begin
            pend_valid_r <= 1'b1;
            pend_tgt_r   <= req_pc_r;
        end else if (state_r == REDIR) begin
            pend_valid_r <= 1'b0;
        end
    end

    // Kill flag: any response retires the single outstanding fetch, so it
    // clears kill even when it arrives late, outside WAIT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            kill_r <= 1'b0;
        end else if (imem_rvalid) begin
            kill_r <= 1'b0;
        end else if (((state_r == WAIT) && br_sel) || timeout_hit_s) begin
            kill_r <= 1'b1;
        end
    end

    // Address of the request in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_pc_r <= {XLEN{1'b0}};
        end else if (grant_s) begin
            req_pc_r <= pc;
        end
    end

    // IF/ID instruction buffer: flush, refill, drain or hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            buf_valid_r <= 1'b0;
            buf_instr_r <= NOP_INSTR;
            buf_pc_r    <= {XLEN{1'b0}};
        end else if (br_sel) begin
            buf_valid_r <= 1'b0;
        end else if (load_s) begin
            buf_valid_r <= 1'b1;
            buf_instr_r <= imem_rdata;
            buf_pc_r    <= req_pc_r;
        end else if (!hazard_stall) begin
            buf_valid_r <= 1'b0;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wd_cnt_r;
    logic       fetch_err_r;

    // Watchdog counter: zeroed on the grant that enters WAIT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wd_cnt_r <= 8'd0;
        end else if (grant_s) begin
            wd_cnt_r <= 8'd0;
        end else if (state_r == WAIT) begin
            wd_cnt_r <= wd_cnt_r + 8'd1;
        end
    end

    assign timeout_hit_s = (state_r == WAIT) && !imem_rvalid && (wd_cnt_r == TIMEOUT_LAST);

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_err_r <= 1'b0;
        end else if (timeout_hit_s) begin
            fetch_err_r <= 1'b1;
        end
    end

    assign fetch_err = fetch_err_r;
`else
    // No watchdog in this build: the comparison is constant false and only
    // keeps the limit parameter referenced.
    assign timeout_hit_s = (TIMEOUT_CYC < 0);
    assign fetch_err     = 1'b0;
`endif

    assign ag_stall_f = stall_s;
    assign ag_br_sel  = br_out_s;
    assign ag_pc_bru  = pend_tgt_r;
    assign imem_req   = issue_s;
    assign imem_addr  = issue_s ? pc : {XLEN{1'b0}};
    assign if_valid   = buf_valid_r;
    assign if_instr   = buf_valid_r ? buf_instr_r : NOP_INSTR;
    assign if_pc      = buf_pc_r;
    assign flush_d    = br_sel && !i_rst;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. The bench models the PC register
// and a single-outstanding instruction memory with a programmable response
// delay. Expected buffer contents are pushed to a scoreboard when the fetch
// is stimulated and popped when the DUT presents the instruction.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] pc;
    logic        hazard_stall;
    logic        br_sel;
    logic [31:0] pc_bru;
    logic        ag_stall_f;
    logic        ag_br_sel;
    logic [31:0] ag_pc_bru;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush_d;
    logic        fetch_err;

    int          errors;
    int          checks;
    int          grant_cnt;
    int          resp_delay;
    int          rsp_cnt;
    logic        rsp_busy;
    logic        auto_resp;
    logic [31:0] rsp_addr;
    exp_t        sb[$];
    exp_t        exp_e;

    fetch_sequencer #(
        .XLEN        (32),
        .NOP_INSTR   (NOP),
        .TIMEOUT_CYC (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .pc           (pc),
        .hazard_stall (hazard_stall),
        .br_sel       (br_sel),
        .pc_bru       (pc_bru),
        .ag_stall_f   (ag_stall_f),
        .ag_br_sel    (ag_br_sel),
        .ag_pc_bru    (ag_pc_bru),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .flush_d      (flush_d),
        .fetch_err    (fetch_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], 16'h0113};
    endfunction

    // One clock: sample PC-register controls and grant before the edge, then
    // update the PC model and the memory responder after it.
    task automatic tick();
        logic        g;
        logic [31:0] ga;
        logic        b;
        logic [31:0] bt;
        logic        s;
        #1;
        g  = imem_req && imem_gnt && !i_rst;
        ga = imem_addr;
        b  = ag_br_sel;
        bt = ag_pc_bru;
        s  = ag_stall_f;
        @(posedge i_clk);
        #1;
        if (i_rst) pc = 32'h0;
        else if (b) pc = bt;
        else if (!s) pc = pc + 32'd4;
        if (g) begin
            grant_cnt++;
            rsp_busy = 1'b1;
            rsp_cnt  = resp_delay;
            rsp_addr = ga;
        end
        if (i_rst) rsp_busy = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (rsp_busy && auto_resp) begin
            if (rsp_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(rsp_addr);
                rsp_busy    = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; br_sel = 1'b0; pc_bru = 32'h0; hazard_stall = 1'b0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        resp_delay = 1; auto_resp = 1'b1; rsp_busy = 1'b0; grant_cnt = 0;
        sb.delete();
        tick();
        tick();
        i_rst = 1'b0;
        grant_cnt = 0;
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; br_sel = 1'b1; pc_bru = 32'h1234; pc = 32'h0;
        hazard_stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #1;
        checks++;
        if ({ag_stall_f, ag_br_sel, ag_pc_bru, imem_req, imem_addr, if_valid, if_instr, if_pc, flush_d, fetch_err}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b br=%b bru=%h req=%b addr=%h v=%b instr=%h ipc=%h flush=%b err=%b",
                     ag_stall_f, ag_br_sel, ag_pc_bru, imem_req, imem_addr, if_valid, if_instr, if_pc, flush_d, fetch_err);
        end
        br_sel = 1'b0;
    endtask

    task automatic test_first_fetch();
        do_reset();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: req=%b addr=%h want 1/0", imem_req, imem_addr); end
        checks++; if (ag_stall_f !== 1'b0) begin errors++; $display("FAIL first_advance: stall=%b want 0", ag_stall_f); end
        sb.push_back('{32'h0, 32'h0050_0093});
        tick();
        checks++; if (ag_stall_f !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL wait_hold: stall=%b req=%b want 1/0", ag_stall_f, imem_req); end
        tick();
        exp_e = sb.pop_front();
        checks++;
        if (if_valid !== 1'b1 || if_instr !== exp_e.instr || if_pc !== exp_e.pc) begin
            errors++;
            $display("FAIL first_buffer: v=%b instr=%h pc=%h want 1/%h/%h", if_valid, if_instr, if_pc, exp_e.instr, exp_e.pc);
        end
        tick();
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP) begin errors++; $display("FAIL buffer_drain: v=%b instr=%h want 0/%h", if_valid, if_instr, NOP); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        tick(); tick(); tick(); tick();
        resp_delay = 3;
        tick();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL fetch_8: addr=%h want 8", imem_addr); end
        tick();
        br_sel = 1'b1; pc_bru = 32'h100;
        #1;
        checks++; if (flush_d !== 1'b1) begin errors++; $display("FAIL flush_wait: got %b want 1", flush_d); end
        tick();
        br_sel = 1'b0;
        #1;
        checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL flush_pulse: got %b want 0", flush_d); end
        tick();
        tick();
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL discard_8: v=%b req=%b want 0/0", if_valid, imem_req); end
        tick();
        checks++;
        if (ag_br_sel !== 1'b1 || ag_pc_bru !== 32'h100 || ag_stall_f !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait: br=%b bru=%h stall=%b want 1/100/0", ag_br_sel, ag_pc_bru, ag_stall_f);
        end
        resp_delay = 1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL target_fetch: req=%b addr=%h want 1/100", imem_req, imem_addr); end
        sb.push_back('{32'h100, mem_word(32'h100)});
        tick();
        tick();
        exp_e = sb.pop_front();
        checks++;
        if (if_valid !== 1'b1 || if_instr !== exp_e.instr || if_pc !== exp_e.pc) begin
            errors++;
            $display("FAIL target_buffer: v=%b instr=%h pc=%h want 1/%h/%h", if_valid, if_instr, if_pc, exp_e.instr, exp_e.pc);
        end
    endtask

    task automatic test_redirect_req();
        do_reset();
        tick();
        br_sel = 1'b1; pc_bru = 32'h200;
        #1;
        checks++; if (imem_req !== 1'b0 || flush_d !== 1'b1) begin errors++; $display("FAIL redir_req_sup: req=%b flush=%b want 0/1", imem_req, flush_d); end
        tick();
        br_sel = 1'b0;
        #1;
        checks++;
        if (ag_br_sel !== 1'b1 || ag_pc_bru !== 32'h200 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_req_next: br=%b bru=%h req=%b want 1/200/0", ag_br_sel, ag_pc_bru, imem_req);
        end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL redir_req_fetch: req=%b addr=%h want 1/200", imem_req, imem_addr); end
        checks++; if (grant_cnt !== 0) begin errors++; $display("FAIL wrong_path: grants=%0d want 0", grant_cnt); end
    endtask

    task automatic test_hazard_hold();
        do_reset();
        tick(); tick(); tick();
        hazard_stall = 1'b1;
        sb.push_back('{32'h0, 32'h0050_0093});
        #1;
        exp_e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_instr !== exp_e.instr || if_pc !== exp_e.pc) begin
                errors++;
                $display("FAIL hazard_hold[%0d]: req=%b v=%b instr=%h pc=%h want 0/1/%h/%h",
                         i, imem_req, if_valid, if_instr, if_pc, exp_e.instr, exp_e.pc);
            end
            tick();
        end
        hazard_stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL hazard_release: req=%b addr=%h want 1/4", imem_req, imem_addr); end
    endtask

    task automatic test_gnt_low_reset();
        do_reset();
        br_sel = 1'b1; pc_bru = 32'h40;
        tick();
        br_sel = 1'b0;
        tick();
        imem_gnt = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h40 || ag_stall_f !== 1'b1 || pc !== 32'h40) begin
                errors++;
                $display("FAIL gnt_low[%0d]: req=%b addr=%h stall=%b pc=%h want 1/40/1/40", i, imem_req, imem_addr, ag_stall_f, pc);
            end
            tick();
        end
        imem_gnt = 1'b1; resp_delay = 5;
        tick();
        checks++; if (ag_pc_bru !== 32'h40 || imem_req !== 1'b0) begin errors++; $display("FAIL pre_reset_wait: bru=%h req=%b want 40/0", ag_pc_bru, imem_req); end
        i_rst = 1'b1;
        #1;
        checks++;
        if ({ag_stall_f, ag_br_sel, ag_pc_bru, imem_req, imem_addr, if_valid, if_instr, if_pc, flush_d, fetch_err}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: stall=%b br=%b bru=%h req=%b addr=%h v=%b instr=%h ipc=%h flush=%b err=%b",
                     ag_stall_f, ag_br_sel, ag_pc_bru, imem_req, imem_addr, if_valid, if_instr, if_pc, flush_d, fetch_err);
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        auto_resp = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL err_early[%0d]: got %b want 0", i, fetch_err); end
        end
        tick();
        checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL timeout: err=%b req=%b want 1/0", fetch_err, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; auto_resp = 1'b1;
        tick();
        checks++; if (ag_br_sel !== 1'b1 || ag_pc_bru !== 32'h0) begin errors++; $display("FAIL timeout_redir: br=%b bru=%h want 1/0", ag_br_sel, ag_pc_bru); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL refetch: req=%b addr=%h want 1/0", imem_req, imem_addr); end
        sb.push_back('{32'h0, 32'h0050_0093});
        tick();
        tick();
        exp_e = sb.pop_front();
        checks++;
        if (if_valid !== 1'b1 || if_instr !== exp_e.instr || if_pc !== exp_e.pc || fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL refetch_buffer: v=%b instr=%h pc=%h err=%b want 1/%h/%h/1", if_valid, if_instr, if_pc, fetch_err, exp_e.instr, exp_e.pc);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        grant_cnt = 0;
        resp_delay = 1;
        rsp_cnt = 0;
        rsp_busy = 1'b0;
        auto_resp = 1'b1;
        rsp_addr = 32'h0;
        test_reset();
        test_first_fetch();
        test_redirect_wait();
        test_redirect_req();
        test_hazard_hold();
        test_gnt_low_reset();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
